fx_bus_master: RTL and testbench



---
 rtl/fx_bus_pkg.sv | 44 ++++
 rtl/fx_bus_master_if.sv | 31 +++
 rtl/fx_rx_timer.sv | 41 ++++
 rtl/fx_bus_master.sv | 219 +++++++++++++++++++++
 tb/tb_fx_bus_master.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fx_bus_pkg.sv
// fx bus shared definitions: header bytes, address layout, FSM state encoding.
// Optional feature macro: FX_MASTER_ACK_EN adds the ACK state to the encoding.
package fx_bus_pkg;

    localparam int unsigned FX_ADDR_W = 22;
    localparam int unsigned FX_DEV_W  = 6;
    localparam int unsigned FX_OFF_W  = FX_ADDR_W - FX_DEV_W;
    localparam int unsigned FX_LEN_W  = 9;   // holds 1..256

    localparam logic [7:0] FX_HDR_WR = 8'hA5;
    localparam logic [7:0] FX_HDR_RD = 8'h5A;
    localparam logic [7:0] FX_ACK    = 8'hAC;

    // Bus address: slaves decode dev, offset walks within the device.
    typedef struct packed {
        logic [FX_DEV_W-1:0] dev;
        logic [FX_OFF_W-1:0] off;
    } fx_addr_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR2,
        ST_ADDR1,
        ST_ADDR0,
        ST_LEN,
        ST_WDATA,
        ST_RREQ,
        ST_RWAIT,
        ST_RSEND
`ifdef FX_MASTER_ACK_EN
        ,
        ST_ACK
`endif
    } fx_state_e;

    // Offset wraps inside the device; dev_id never changes.
    function automatic fx_addr_t fx_addr_inc(input fx_addr_t a);
        fx_addr_t r;
        r     = a;
        r.off = a.off + FX_OFF_W'(1);
        return r;
    endfunction

endpackage

// File: rtl/fx_bus_master_if.sv
// Host byte-stream and fx register bus signals of the bus master.
//   rx_data/rx_vld/rx_rdy : host command bytes into the master
//   tx_data/tx_vld/tx_rdy : response bytes back to the host
//   fx_waddr/fx_wr/fx_data, fx_raddr/fx_rd, fx_q : register bus
interface fx_bus_master_if;
    import fx_bus_pkg::*;

    logic [7:0]           rx_data;
    logic                 rx_vld;
    logic                 rx_rdy;
    logic [7:0]           tx_data;
    logic                 tx_vld;
    logic                 tx_rdy;
    logic [FX_ADDR_W-1:0] fx_waddr;
    logic                 fx_wr;
    logic [7:0]           fx_data;
    logic [FX_ADDR_W-1:0] fx_raddr;
    logic                 fx_rd;
    logic [7:0]           fx_q;

    modport master (
        input  rx_data, rx_vld, tx_rdy, fx_q,
        output rx_rdy, tx_data, tx_vld, fx_waddr, fx_wr, fx_data, fx_raddr, fx_rd
    );

    modport slave (
        output rx_data, rx_vld, tx_rdy, fx_q,
        input  rx_rdy, tx_data, tx_vld, fx_waddr, fx_wr, fx_data, fx_raddr, fx_rd
    );

endinterface

// File: rtl/fx_rx_timer.sv
// Inter-byte idle counter for a packet in flight.
//   clk_i, rst_i : clock, synchronous active-high reset
//   en_i         : packet in progress (counter held at 0 otherwise)
//   clr_i        : a byte was accepted this cycle
//   expired_o    : TIMEOUT_CYC idle cycles have elapsed (saturates)
module fx_rx_timer #(
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic expired_o
);

    localparam int unsigned     CNT_W = 17;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count idle cycles, saturating at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || clr_i) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/fx_bus_master.sv
// fx bus initiator: turns host command packets into fx_wr/fx_rd accesses and
// returns read data as a byte stream. One access at a time.
//   clk_sys, rst : clock, synchronous active-high reset
//   bus          : fx_bus_master_if.master (host rx/tx streams + register bus)
//   busy         : FSM not in IDLE
//   err          : one-cycle pulse on a bad header or inter-byte timeout
// Optional feature macro: FX_MASTER_ACK_EN -- a write packet returns byte 0xAC.
module fx_bus_master
    import fx_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 65535,
    parameter int unsigned RD_LAT      = 1
) (
    input  logic            clk_sys,
    input  logic            rst,
    fx_bus_master_if.master bus,
    output logic            busy,
    output logic            err
);

    localparam int unsigned WAIT_W = 2;

    fx_state_e            state_q, state_d;
    logic                 hdr_rd_q, hdr_rd_d;
    fx_addr_t             addr_q, addr_d;
    logic [FX_LEN_W-1:0]  cnt_q, cnt_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic                 rx_rdy_q, rx_rdy_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_vld_q, tx_vld_d;
    logic [FX_ADDR_W-1:0] fx_waddr_q, fx_waddr_d;
    logic                 fx_wr_q, fx_wr_d;
    logic [7:0]           fx_data_q, fx_data_d;
    logic [FX_ADDR_W-1:0] fx_raddr_q, fx_raddr_d;
    logic                 fx_rd_q, fx_rd_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;

    logic rx_fire;
    logic tx_fire;
    logic tmr_en;
    logic tmr_expired;

    assign rx_fire = bus.rx_vld && rx_rdy_q;
    assign tx_fire = tx_vld_q && bus.tx_rdy;
    assign tmr_en  = state_q inside {ST_ADDR2, ST_ADDR1, ST_ADDR0, ST_LEN, ST_WDATA};

    fx_rx_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx_timer (
        .clk_i     (clk_sys),
        .rst_i     (rst),
        .en_i      (tmr_en),
        .clr_i     (rx_fire),
        .expired_o (tmr_expired)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        hdr_rd_d   = hdr_rd_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        wait_d     = wait_q;
        tx_data_d  = tx_data_q;
        tx_vld_d   = tx_vld_q;
        fx_waddr_d = fx_waddr_q;
        fx_data_d  = fx_data_q;
        fx_raddr_d = fx_raddr_q;
        fx_wr_d    = 1'b0;
        fx_rd_d    = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_fire) begin
                    if (bus.rx_data == FX_HDR_WR || bus.rx_data == FX_HDR_RD) begin
                        hdr_rd_d = (bus.rx_data == FX_HDR_RD);
                        state_d  = ST_ADDR2;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ADDR2: begin
                if (rx_fire) begin
                    addr_d.dev = bus.rx_data[FX_DEV_W-1:0];
                    state_d    = ST_ADDR1;
                end
            end
            ST_ADDR1: begin
                if (rx_fire) begin
                    addr_d.off[15:8] = bus.rx_data;
                    state_d          = ST_ADDR0;
                end
            end
            ST_ADDR0: begin
                if (rx_fire) begin
                    addr_d.off[7:0] = bus.rx_data;
                    state_d         = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_fire) begin
                    cnt_d   = (bus.rx_data == 8'h00) ? FX_LEN_W'(256) : FX_LEN_W'(bus.rx_data);
                    state_d = hdr_rd_q ? ST_RREQ : ST_WDATA;
                end
            end
            ST_WDATA: begin
                if (rx_fire) begin
                    fx_wr_d    = 1'b1;
                    fx_waddr_d = addr_q;
                    fx_data_d  = bus.rx_data;
                    addr_d     = fx_addr_inc(addr_q);
                    cnt_d      = cnt_q - FX_LEN_W'(1);
                    if (cnt_q == FX_LEN_W'(1)) begin
`ifdef FX_MASTER_ACK_EN
                        tx_data_d = FX_ACK;
                        tx_vld_d  = 1'b1;
                        state_d   = ST_ACK;
`else
                        state_d   = ST_IDLE;
`endif
                    end
                end
            end
            ST_RREQ: begin
                fx_rd_d    = 1'b1;
                fx_raddr_d = addr_q;
                wait_d     = '0;
                state_d    = ST_RWAIT;
            end
            // fx_rd is on the bus during the first RWAIT cycle; data is valid RD_LAT later.
            ST_RWAIT: begin
                if (wait_q == WAIT_W'(RD_LAT)) begin
                    tx_data_d = bus.fx_q;
                    tx_vld_d  = 1'b1;
                    state_d   = ST_RSEND;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_RSEND: begin
                if (tx_fire) begin
                    tx_vld_d = 1'b0;
                    addr_d   = fx_addr_inc(addr_q);
                    cnt_d    = cnt_q - FX_LEN_W'(1);
                    state_d  = (cnt_q == FX_LEN_W'(1)) ? ST_IDLE : ST_RREQ;
                end
            end
`ifdef FX_MASTER_ACK_EN
            ST_ACK: begin
                if (tx_fire) begin
                    tx_vld_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // An accepted byte in the same cycle rescues the packet.
        if (tmr_en && tmr_expired && !rx_fire) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end

        rx_rdy_d = state_d inside {ST_IDLE, ST_ADDR2, ST_ADDR1, ST_ADDR0, ST_LEN, ST_WDATA};
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hdr_rd_q   <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
            wait_q     <= '0;
            rx_rdy_q   <= 1'b0;
            tx_data_q  <= '0;
            tx_vld_q   <= 1'b0;
            fx_waddr_q <= '0;
            fx_wr_q    <= 1'b0;
            fx_data_q  <= '0;
            fx_raddr_q <= '0;
            fx_rd_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_rd_q   <= hdr_rd_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            rx_rdy_q   <= rx_rdy_d;
            tx_data_q  <= tx_data_d;
            tx_vld_q   <= tx_vld_d;
            fx_waddr_q <= fx_waddr_d;
            fx_wr_q    <= fx_wr_d;
            fx_data_q  <= fx_data_d;
            fx_raddr_q <= fx_raddr_d;
            fx_rd_q    <= fx_rd_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign bus.rx_rdy   = rx_rdy_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_vld   = tx_vld_q;
    assign bus.fx_waddr = fx_waddr_q;
    assign bus.fx_wr    = fx_wr_q;
    assign bus.fx_data  = fx_data_q;
    assign bus.fx_raddr = fx_raddr_q;
    assign bus.fx_rd    = fx_rd_q;
    assign busy         = busy_q;
    assign err          = err_q;

endmodule

// File: tb/tb_fx_bus_master.sv
// Directed bench for fx_bus_master with a dev_id 0 register slave model
// (256 byte registers, reset value = register index, 1-cycle read latency).
module tb_fx_bus_master;
    import fx_bus_pkg::*;

    localparam int unsigned TIMEOUT_CYC = 65535;
    localparam int unsigned RD_LAT      = 1;

    logic clk_sys = 1'b0;
    logic rst;
    logic busy;
    logic err;

    fx_bus_master_if bus ();

    fx_bus_master #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .RD_LAT      (RD_LAT)
    ) dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk_sys = ~clk_sys;

    // Register slave, dev_id 0, offsets 0x0000..0x00FF.
    logic [7:0] mem [256];
    always @(posedge clk_sys) begin
        if (rst) begin
            bus.fx_q <= 8'h00;
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
        end else begin
            bus.fx_q <= (bus.fx_rd && bus.fx_raddr[21:8] == 14'h0) ? mem[bus.fx_raddr[7:0]] : 8'h00;
            if (bus.fx_wr && bus.fx_waddr[21:8] == 14'h0) mem[bus.fx_waddr[7:0]] <= bus.fx_data;
        end
    end

    // Strobe monitor, sampled mid-cycle.
    int unsigned cyc = 0, n_wr = 0, n_rd = 0, n_err = 0, n_both = 0;
    logic [29:0] wlog [$];
    int unsigned wcyc [$];
    logic [21:0] rlog [$];
    always @(negedge clk_sys) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (bus.fx_wr) begin
                n_wr <= n_wr + 1;
                wlog.push_back({bus.fx_waddr, bus.fx_data});
                wcyc.push_back(cyc);
            end
            if (bus.fx_rd) begin
                n_rd <= n_rd + 1;
                rlog.push_back(bus.fx_raddr);
            end
            if (err) n_err <= n_err + 1;
            if (bus.fx_wr && bus.fx_rd) n_both <= n_both + 1;
        end
    end

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        bit   done;
        done        = 1'b0;
        bus.rx_data = b;
        bus.rx_vld  = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            rdy = bus.rx_rdy;
            tick(1);
            if (rdy) done = 1'b1;
        end
        bus.rx_vld = 1'b0;
        if (!done) check_eq("rx_accept_bound", 32'd0, 32'd1);
    endtask

    task automatic send_cmd(input logic [7:0] hdr, a2, a1, a0, len);
        send_byte(hdr);
        send_byte(a2);
        send_byte(a1);
        send_byte(a0);
        send_byte(len);
    endtask

    task automatic recv_byte(output logic [7:0] b);
        bit got;
        got        = 1'b0;
        b          = 8'h00;
        bus.tx_rdy = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            if (bus.tx_vld) begin
                b   = bus.tx_data;
                got = 1'b1;
            end
            tick(1);
        end
        bus.tx_rdy = 1'b0;
        if (!got) check_eq("tx_wait_bound", 32'd0, 32'd1);
    endtask

    task automatic wait_tx_vld();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            if (bus.tx_vld) got = 1'b1;
            else tick(1);
        end
        if (!got) check_eq("tx_vld_bound", 32'd0, 32'd1);
    endtask

    task automatic take_ack();
`ifdef FX_MASTER_ACK_EN
        logic [7:0] b;
        recv_byte(b);
        check_eq("ack_byte", 32'(b), 32'(FX_ACK));
`endif
    endtask

    initial begin
        logic [7:0]  b;
        int unsigned base, n, e0;
        bit          stable;

        rst         = 1'b1;
        bus.rx_data = 8'h00;
        bus.rx_vld  = 1'b0;
        bus.tx_rdy  = 1'b0;
        tick(3);
        check_eq("rst_rx_rdy", 32'(bus.rx_rdy), 32'd0);
        check_eq("rst_tx_vld", 32'(bus.tx_vld), 32'd0);
        check_eq("rst_strobes", 32'({bus.fx_wr, bus.fx_rd}), 32'd0);
        check_eq("rst_busy_err", 32'({busy, err}), 32'd0);
        rst = 1'b0;
        tick(1);
        check_eq("idle_rx_rdy", 32'(bus.rx_rdy), 32'd1);

        // Two-byte write to dev 0, offset 0x20: cfg_th = 0x1234.
        wlog.delete(); wcyc.delete();
        send_cmd(FX_HDR_WR, 8'h00, 8'h00, 8'h20, 8'h02);
        send_byte(8'h34);
        send_byte(8'h12);
        tick(3);
        take_ack();
        check_eq("wr1_count", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            check_eq("wr1_beat0", 32'(wlog[0]), 32'({22'h000020, 8'h34}));
            check_eq("wr1_beat1", 32'(wlog[1]), 32'({22'h000021, 8'h12}));
            check_eq("wr1_b2b", wcyc[1] - wcyc[0], 32'd1);
        end
        check_eq("wr1_cfg_th", 32'({mem[8'h21], mem[8'h20]}), 32'h1234);
        check_eq("wr1_hold", 32'({bus.fx_waddr, bus.fx_data}), 32'({22'h000021, 8'h12}));
        check_eq("wr1_busy", 32'(busy), 32'd0);

        // 4-byte read from offset 0x80 of reset-valued registers.
        rlog.delete();
        send_cmd(FX_HDR_RD, 8'h00, 8'h00, 8'h80, 8'h04);
        for (int i = 0; i < 4; i++) begin
            recv_byte(b);
            check_eq($sformatf("rd1_byte%0d", i), 32'(b), 32'(8'h80 + i));
        end
        tick(2);
        check_eq("rd1_count", 32'(rlog.size()), 32'd4);
        if (rlog.size() == 4) check_eq("rd1_addr3", 32'(rlog[3]), 32'h000083);
        check_eq("rd1_busy", 32'(busy), 32'd0);

        // Same read with the host stalling 10 cycles on byte 2.
        base = n_rd;
        send_cmd(FX_HDR_RD, 8'h00, 8'h00, 8'h80, 8'h04);
        recv_byte(b);
        check_eq("rd2_byte0", 32'(b), 32'h80);
        wait_tx_vld();
        stable = 1'b1;
        repeat (10) begin
            if (!(bus.tx_vld && bus.tx_data == 8'h81)) stable = 1'b0;
            tick(1);
        end
        check_eq("rd2_stall_stable", 32'(stable), 32'd1);
        check_eq("rd2_no_rd_in_stall", n_rd - base, 32'd2);
        for (int i = 1; i < 4; i++) begin
            recv_byte(b);
            check_eq($sformatf("rd2_byte%0d", i), 32'(b), 32'(8'h80 + i));
        end
        tick(3);
        check_eq("rd2_rd_total", n_rd - base, 32'd4);

        // Offset wrap keeps dev_id.
        wlog.delete();
        send_cmd(FX_HDR_WR, 8'h03, 8'hFF, 8'hFF, 8'h02);
        send_byte(8'hAA);
        send_byte(8'hBB);
        tick(3);
        take_ack();
        check_eq("wrap_count", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            check_eq("wrap_beat0", 32'(wlog[0]), 32'({22'h03FFFF, 8'hAA}));
            check_eq("wrap_beat1", 32'(wlog[1]), 32'({22'h030000, 8'hBB}));
        end

        // LEN 0 means 256 data bytes.
        wlog.delete();
        send_cmd(FX_HDR_WR, 8'h05, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 256; i++) send_byte(8'(i));
        tick(3);
        take_ack();
        check_eq("len256_count", 32'(wlog.size()), 32'd256);
        if (wlog.size() == 256) check_eq("len256_last", 32'(wlog[255]), 32'({22'h0500FF, 8'hFF}));
        check_eq("len256_busy", 32'(busy), 32'd0);

        // Bad header: err pulse, no bus activity.
        e0   = n_err;
        base = n_wr + n_rd;
        send_byte(8'h77);
        tick(3);
        check_eq("badhdr_err", n_err - e0, 32'd1);
        check_eq("badhdr_strobes", n_wr + n_rd - base, 32'd0);
        check_eq("badhdr_busy", 32'(busy), 32'd0);

        // Stalled packet times out after TIMEOUT_CYC idle cycles.
        send_byte(FX_HDR_RD);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        e0 = n_err;
        n  = 0;
        while (n_err == e0 && n < TIMEOUT_CYC + 20) begin
            tick(1);
            n++;
        end
        tick(3);
        check_eq("timeout_err", n_err - e0, 32'd1);
        check_eq("timeout_window", 32'(n >= TIMEOUT_CYC && n <= TIMEOUT_CYC + 3), 32'd1);
        check_eq("timeout_busy", 32'(busy), 32'd0);
        send_cmd(FX_HDR_RD, 8'h00, 8'h00, 8'h21, 8'h01);
        recv_byte(b);
        check_eq("post_timeout_read", 32'(b), 32'h12);

        // Reset while a read waits in RSEND.
        send_cmd(FX_HDR_RD, 8'h00, 8'h00, 8'h80, 8'h04);
        recv_byte(b);
        wait_tx_vld();
        rst = 1'b1;
        tick(1);
        check_eq("rst_mid_tx_vld", 32'(bus.tx_vld), 32'd0);
        check_eq("rst_mid_strobes", 32'({bus.fx_wr, bus.fx_rd}), 32'd0);
        check_eq("rst_mid_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick(2);

        // Recovery read; A2 bits [7:6] are ignored.
        rlog.delete();
        send_cmd(FX_HDR_RD, 8'hC0, 8'h00, 8'h85, 8'h01);
        recv_byte(b);
        check_eq("recover_data", 32'(b), 32'h85);
        tick(2);
        if (rlog.size() == 1) check_eq("recover_addr", 32'(rlog[0]), 32'h000085);
        else check_eq("recover_rd_count", 32'(rlog.size()), 32'd1);
        check_eq("no_wr_rd_overlap", n_both, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
